// File: rtl/pc_ctrl_if.sv
// Bundle between the PC controller and the fetch/jump logic.
// The master side drives the strobes; the slave side (pc_ctrl) returns PC and stack status.
interface pc_ctrl_if;
   logic        inc;
   logic        pcoe;
   logic [22:0] pcin;
   logic        call;
   logic        ret;
   logic        clr_err;
   logic [22:0] pc;
   logic [4:0]  depth;
   logic        full;
   logic        empty;
   logic        ovf;
   logic        unf;

   modport master (
      output inc, pcoe, pcin, call, ret, clr_err,
      input  pc, depth, full, empty, ovf, unf
   );

   modport slave (
      input  inc, pcoe, pcin, call, ret, clr_err,
      output pc, depth, full, empty, ovf, unf
   );
endinterface

// File: rtl/pc_ctrl.sv
// Program counter with a LIFO return-address stack and sticky overflow/underflow flags.
// Next-PC priority: taken jump, then return, then increment, then hold.
module pc_ctrl #(
   parameter int          DEPTH    = 8,
   parameter logic [22:0] RESET_PC = 23'h0
) (
   input  logic      clk,
   input  logic      rst,
   pc_ctrl_if.slave  bus
);

   localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [4:0] DEPTH_CNT = 5'(DEPTH);

   typedef enum logic [1:0] {
      SRC_HOLD,
      SRC_JUMP,
      SRC_POP,
      SRC_INC
   } pc_src_e;

   logic [22:0]   pc_q, pc_d;
   logic [4:0]    sp_q, sp_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic [22:0]   stack_q [DEPTH];
   logic [22:0]   stack_d [DEPTH];

   logic          full, empty;
   logic          push, pop;
   logic          ovf_evt, unf_evt;
   logic [AW-1:0] wr_idx, top_idx;
   pc_src_e       pc_src;

   assign full    = (sp_q == DEPTH_CNT);
   assign empty   = (sp_q == 5'd0);
   assign wr_idx  = AW'(sp_q);
   assign top_idx = AW'(sp_q - 5'd1);

   // A taken jump masks ret completely; a call only matters when the jump is taken.
   assign push    = bus.pcoe & bus.call & ~full;
   assign ovf_evt = bus.pcoe & bus.call & full;
   assign pop     = ~bus.pcoe & bus.ret & ~empty;
   assign unf_evt = ~bus.pcoe & bus.ret & empty;

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
      pc_src = SRC_HOLD;
      if (bus.pcoe) begin
         pc_src = SRC_JUMP;
      end else if (bus.ret) begin
         pc_src = empty ? SRC_HOLD : SRC_POP;
      end else if (bus.inc) begin
         pc_src = SRC_INC;
      end
   end

   always_comb begin
      pc_d = pc_q;
      unique case (pc_src)
         SRC_JUMP: pc_d = bus.pcin;
         SRC_POP:  pc_d = stack_q[top_idx];
         SRC_INC:  pc_d = pc_q + 23'd1;
         default:  pc_d = pc_q;
      endcase
   end

   always_comb begin
      sp_d = sp_q;
      if (push) begin
         sp_d = sp_q + 5'd1;
      end else if (pop) begin
         sp_d = sp_q - 5'd1;
      end
   end

   // A new error event outranks a simultaneous clear.
   always_comb begin
      ovf_d = ovf_evt | (ovf_q & ~bus.clr_err);
      unf_d = unf_evt | (unf_q & ~bus.clr_err);
   end

   always_comb begin
      stack_d = stack_q;
      if (push) begin
         stack_d[wr_idx] = pc_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         sp_q  <= 5'd0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // NOTE: the stack array is not reset; entries at or above the pointer are never read.
   always_ff @(posedge clk) begin
      stack_q <= stack_d;
   end

   assign bus.pc    = pc_q;
   assign bus.depth = sp_q;
   assign bus.full  = full;
   assign bus.empty = empty;
   assign bus.ovf   = ovf_q;
   assign bus.unf   = unf_q;

endmodule

// File: doc/pc_ctrl.md
PC_CTRL -- requirements
Module: pc_ctrl

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous, active-high reset, rst.
REQ-002 Parameter: DEPTH, default 8, return-stack entries; legal values are powers of two, 2..16.
REQ-003 Parameter: RESET_PC, default 23'h0, PC value loaded on reset.
REQ-004 Port: clk  in  1  system clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  asynchronous active-high reset.
REQ-006 Port: inc  in  1  advance PC by one this cycle (fetch or operand consumed).
REQ-007 Port: pcoe  in  1  jump-taken strobe from the jump unit.
REQ-008 Port: pcin  in  23  jump target from the jump unit; valid when pcoe=1.
REQ-009 Port: call  in  1  current jump is a call; push return address if the jump is taken.
REQ-010 Port: ret  in  1  return; pop the stack top into PC.
REQ-011 Port: clr_err  in  1  clear the sticky error flags.
REQ-012 Port: pc  out  23  current program counter; feeds the jump unit's PC input.
REQ-013 Port: depth  out  5  number of valid stack entries, 0..DEPTH.
REQ-014 Port: full  out  1  high when depth==DEPTH.
REQ-015 Port: empty  out  1  high when depth==0.
REQ-016 Port: ovf  out  1  sticky flag: call pushed while full.
REQ-017 Port: unf  out  1  sticky flag: ret issued while empty.

Function
REQ-018 Next-PC priority, highest first: pcoe, then ret, then inc, then hold.
REQ-019 pcoe=1: pc <= pcin on the next edge, and inc is ignored that cycle.
REQ-020 pcoe=1 and call=1, not full: push the current pc (the pre-load value), then depth += 1 in the same edge.
REQ-021 pcoe=1 and call=1, full: no push, depth unchanged, ovf <= 1; the jump is still taken.
REQ-022 call=1 with pcoe=0 (condition false): no push and no flag change; inc is honoured.
REQ-023 ret=1 with pcoe=0, not empty: pc <= top entry, depth -= 1.
REQ-024 ret=1 with pcoe=0, empty: pc unchanged (inc ignored), depth unchanged, unf <= 1.
REQ-025 ret=1 with pcoe=1: ret is ignored entirely, with no pop and no flag change.
REQ-026 inc only: pc <= pc + 1, modulo 2^23; 23'h7FFFFF wraps to 23'h000000 with no flag.
REQ-027 Stack is LIFO, implemented as a register array with a pointer.
REQ-028 Stack entries beyond depth are don't-care and need not be cleared.
REQ-029 full, empty and depth SHALL be combinational from the pointer, valid in the same cycle.
REQ-030 All next-state effects take one cycle; pc reflects a load or pop after exactly one rising edge.
REQ-031 clr_err=1 clears ovf and unf on the next edge.
REQ-032 If clr_err=1 coincides with a new error event, the error wins and the flag stays 1.
REQ-033 Flags are sticky until cleared by clr_err or rst.

Reset
REQ-034 On rst=1, asynchronously: pc=RESET_PC, depth=0, empty=1, full=0, ovf=0, unf=0.
REQ-035 Reset asserted mid-sequence, e.g. during a call or ret, SHALL discard the operation; no partial push or pop survives.
REQ-036 After rst deasserts, the first rising edge SHALL apply normal next-state rules.

Verification
REQ-037 Reset, then inc for 3 cycles -> pc=0,1,2,3; depth=0; empty=1.
REQ-038 pc=0x000010, pcoe=1, call=1, pcin=0x000200 -> pc=0x000200, depth=1; then ret=1 -> pc=0x000010, depth=0, empty=1.
REQ-039 DEPTH=8: nine taken calls -> depth=8, full=1, ovf=1 after the 9th; pc=9th target; eight rets return the first eight pushed addresses in reverse order.
REQ-040 Empty stack, ret=1 with inc=1 -> pc unchanged, unf=1; clr_err=1 -> unf=0.
REQ-041 pc=0x7FFFFF, inc=1 -> pc=0x000000. Same cycle pcoe=1, ret=1, pcin=0x123456 -> pc=0x123456 and depth unchanged.
REQ-042 Assert rst mid-way through a call burst with depth=3 -> immediately pc=RESET_PC, depth=0, flags cleared.
